instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
// - Fetch stage between the instruction RAM and the decode stage. Owns the PC and drives the RAM's byte ADDR.
// - Reads RAM Q combinationally the same cycle and registers it, with its PC, into a valid/ready output slot.
// - Folds unconditional JUMPs locally, accepts branch redirects from execute, and stops fetching at HALT.
// PARAMETERS
// - ADDR_W    10  byte-address width; PC[0] is always 0
// - DATA_W    16  instruction width
// - RESET_PC  0   byte address of the first instruction
// PORTS
// - CLK          in   1       rising-edge clock
// - RESET        in   1       synchronous, active-high; RAM is initialised while it is high
// - IMEM_ADDR    out  ADDR_W  byte address to instruction RAM; equals the PC register
// - IMEM_Q       in   DATA_W  RAM data for IMEM_ADDR, valid in the same cycle
// - INSTR_VALID  out  1       output slot holds an instruction
// - INSTR_READY  in   1       decode accepts the slot this cycle
// - INSTR        out  DATA_W  instruction word
// - INSTR_PC     out  ADDR_W  byte address of INSTR
// - REDIRECT     in   1       taken branch: flush and refetch
// - REDIRECT_PC  in   ADDR_W  new byte address; bit 0 ignored (forced 0)
// - HALTED       out  1       a HALT has been accepted by decode
// BEHAVIOUR
// - Reset values: PC=RESET_PC, INSTR_VALID=0, INSTR=0, INSTR_PC=0, HALTED=0, state=RUN.
// - Decode of IMEM_Q: opcode = IMEM_Q[15:12].
//   - 4'b0000 = HALT.
//   - 4'b0001 = JUMP; target word = IMEM_Q[8:0]; IMEM_Q[11:9] must be 0 and is ignored.
// - Load condition: load = state==RUN && (!INSTR_VALID || INSTR_READY) && !REDIRECT.
// - FSM RUN, on load with a normal opcode:
//   - slot <= {IMEM_Q, PC}, INSTR_VALID <= 1, PC <= PC+2.
//   - PC wraps from 2^ADDR_W-2 to 0.
// - FSM RUN, on load with HALT:
//   - slot <= HALT, INSTR_VALID <= 1, PC holds, state -> HALT_WAIT.
// - FSM HALT_WAIT:
//   - No RAM reads are used; PC holds.
//   - When INSTR_READY=1: INSTR_VALID <= 0, HALTED <= 1, state -> HALTED.
// - FSM HALTED:
//   - Terminal; only RESET leaves it. REDIRECT is ignored. INSTR_VALID stays 0.
// - Latency: 1 cycle from IMEM_ADDR to INSTR_VALID. Sustained throughput is 1 instruction/cycle while READY=1.
// - Backpressure: when VALID=1 and READY=0, INSTR, INSTR_PC, VALID and PC hold stable.
// - REDIRECT, in RUN or HALT_WAIT (highest priority):
//   - Next cycle: INSTR_VALID=0, PC=REDIRECT_PC & ~1, state=RUN.
//   - A speculatively fetched HALT is cancelled and HALTED stays 0.
// - REDIRECT together with a handshake in the same cycle: the handshake completes (decode owns the word), then the redirect applies.
// - REDIRECT together with HALT acceptance in HALT_WAIT: HALT acceptance wins (HALTED <= 1) and the redirect is dropped.
// - RESET mid-operation: all state returns to reset values on the next edge, regardless of FSM state.
// - No output is valid while RESET=1. The first INSTR_VALID comes 1 cycle after RESET falls, with INSTR_PC=RESET_PC.
// CONFIGURATION
// - IFETCH_JUMP_FOLD_EN defined:
//   - When load and opcode==JUMP: PC <= {target,1'b0}; the slot is not loaded (VALID <= 0 unless it was held).
//   - The JUMP never reaches decode. This costs one bubble per JUMP.
//   - A JUMP whose target equals its own PC loops without producing output; REDIRECT and RESET still work.
// - IFETCH_JUMP_FOLD_EN undefined:
//   - JUMP is treated as a normal opcode and presented downstream.
//   - Decode must resolve it through REDIRECT.
// TESTING
// - Sequential flow: release RESET with READY=1 and words 0..3 non-control -> INSTR_PC = 0,2,4,6 on consecutive cycles; first VALID 1 cycle after RESET falls.
// - Backpressure: VALID=1 at PC=4, hold READY=0 for 3 cycles -> INSTR, INSTR_PC=4 and IMEM_ADDR=6 stable; after READY=1, next INSTR_PC=6 (no skip, no repeat).
// - Jump fold (macro on): word 4=16'h1089, word 137=HALT -> word 3 output, one bubble, then INSTR_PC=274 with INSTR=HALT; the JUMP is never VALID.
// - Jump passthrough (macro off): word 4=16'h1089 -> VALID with INSTR_PC=8 and INSTR=16'h1089; PC continues at 10.
// - Redirect: REDIRECT=1 with REDIRECT_PC=10'h041 while VALID=1, READY=0 -> next cycle VALID=0 and IMEM_ADDR=10'h040; following cycle INSTR_PC=10'h040.
// - Halt:
//   - HALT presented with READY=0, then REDIRECT to 0 -> HALTED stays 0 and fetch resumes at 0.
//   - HALT accepted -> HALTED=1, VALID=0, and IMEM_ADDR frozen thereafter; a later REDIRECT has no effect.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads IMEM_Q the same cycle into a valid/ready slot; macro IFETCH_JUMP_FOLD_EN folds JUMPs locally.
// Latency: one cycle from IMEM_ADDR to INSTR_VALID; sustains one instruction per cycle while INSTR_READY is high.
// Backpressure: a valid slot with INSTR_READY low holds INSTR, INSTR_PC, INSTR_VALID and the PC stable.
module instr_fetch_unit #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 16,
    parameter int RESET_PC = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic [DATA_W-1:0] IMEM_Q,
    output logic              INSTR_VALID,
    input  logic              INSTR_READY,
    output logic [DATA_W-1:0] INSTR,
    output logic [ADDR_W-1:0] INSTR_PC,
    input  logic              REDIRECT,
    input  logic [ADDR_W-1:0] REDIRECT_PC,
    output logic              HALTED
);

    typedef enum logic [1:0] {
        S_RUN,
        S_HALT_WAIT,
        S_HALTED
    } state_t;

    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC) & ~ADDR_W'(1);

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] pc_q, pc_n;
    logic              vld_q, vld_n;
    logic [DATA_W-1:0] instr_q, instr_n;
    logic [ADDR_W-1:0] ipc_q, ipc_n;
    logic              halted_q, halted_n;

    logic [3:0]        opcode;
    logic              is_halt;
    logic              load;
    logic [ADDR_W-1:0] redir_pc;

    assign opcode   = IMEM_Q[DATA_W-1:DATA_W-4];
    assign is_halt  = (opcode == 4'b0000);
    assign load     = (state_q == S_RUN) && (!vld_q || INSTR_READY) && !REDIRECT;
    assign redir_pc = REDIRECT_PC & ~ADDR_W'(1);

`ifdef IFETCH_JUMP_FOLD_EN
    logic is_jump;
    assign is_jump = (opcode == 4'b0001);
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_RUN;
            pc_q     <= PC_INIT;
            vld_q    <= 1'b0;
            instr_q  <= '0;
            ipc_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            pc_q     <= pc_n;
            vld_q    <= vld_n;
            instr_q  <= instr_n;
            ipc_q    <= ipc_n;
            halted_q <= halted_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        pc_n     = pc_q;
        vld_n    = vld_q;
        instr_n  = instr_q;
        ipc_n    = ipc_q;
        halted_n = halted_q;
        case (state_q)
            S_RUN: begin
                if (REDIRECT) begin
                    vld_n = 1'b0;
                    pc_n  = redir_pc;
                end else if (load) begin
                    if (is_halt) begin
                        instr_n = IMEM_Q;
                        ipc_n   = pc_q;
                        vld_n   = 1'b1;
                        state_n = S_HALT_WAIT;
`ifdef IFETCH_JUMP_FOLD_EN
                    end else if (is_jump) begin
                        // Slot was free or just consumed, so the JUMP leaves a bubble.
                        pc_n  = ADDR_W'({IMEM_Q[8:0], 1'b0});
                        vld_n = 1'b0;
`endif
                    end else begin
                        instr_n = IMEM_Q;
                        ipc_n   = pc_q;
                        vld_n   = 1'b1;
                        pc_n    = pc_q + ADDR_W'(2);
                    end
                end
            end
            S_HALT_WAIT: begin
                // HALT acceptance outranks a simultaneous redirect.
                if (INSTR_READY) begin
                    vld_n    = 1'b0;
                    halted_n = 1'b1;
                    state_n  = S_HALTED;
                end else if (REDIRECT) begin
                    vld_n   = 1'b0;
                    pc_n    = redir_pc;
                    state_n = S_RUN;
                end
            end
            default: begin
                vld_n = 1'b0;
            end
        endcase
    end

    assign IMEM_ADDR   = pc_q;
    assign INSTR_VALID = vld_q;
    assign INSTR       = instr_q;
    assign INSTR_PC    = ipc_q;
    assign HALTED      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed table-driven bench for instr_fetch_unit with a behavioural instruction RAM.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  imem_addr;
    logic [15:0] imem_q;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [9:0]  instr_pc;
    logic        redirect;
    logic [9:0]  redirect_pc;
    logic        halted;

    logic [15:0] mem [0:511];
    assign imem_q = mem[imem_addr[9:1]];

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(10), .DATA_W(16), .RESET_PC(0)) dut (
        .CLK        (clk),
        .RESET      (reset),
        .IMEM_ADDR  (imem_addr),
        .IMEM_Q     (imem_q),
        .INSTR_VALID(instr_valid),
        .INSTR_READY(instr_ready),
        .INSTR      (instr),
        .INSTR_PC   (instr_pc),
        .REDIRECT   (redirect),
        .REDIRECT_PC(redirect_pc),
        .HALTED     (halted)
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        redir;
        logic [9:0]  rpc;
        logic        e_vld;
        logic [9:0]  e_addr;
        logic        e_halt;
        logic        chk;
        logic [15:0] e_instr;
        logic [9:0]  e_pc;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic v(input logic rst, input logic rdy, input logic redir, input logic [9:0] rpc,
                     input logic e_vld, input logic [9:0] e_addr, input logic e_halt,
                     input logic chk, input logic [15:0] e_instr, input logic [9:0] e_pc);
        vec_t r;
        r.rst = rst; r.rdy = rdy; r.redir = redir; r.rpc = rpc;
        r.e_vld = e_vld; r.e_addr = e_addr; r.e_halt = e_halt;
        r.chk = chk; r.e_instr = e_instr; r.e_pc = e_pc;
        vq.push_back(r);
    endtask

    task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic rdy, input logic redir, input logic [9:0] rpc);
        @(negedge clk);
        reset       = rst;
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'h2000 | 16'(i);
        mem[4]   = 16'h1089;
        mem[130] = 16'h0000;
        mem[137] = 16'h0000;

        reset = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;

        //  rst rdy red rpc      vld addr    hlt chk instr     pc
        v(1, 1, 0, 10'h000,  0, 10'h000, 0, 1, 16'h0000, 10'h000);
        v(1, 1, 0, 10'h000,  0, 10'h000, 0, 1, 16'h0000, 10'h000);
        v(0, 1, 0, 10'h000,  1, 10'h002, 0, 1, 16'h2000, 10'h000);
        v(0, 1, 0, 10'h000,  1, 10'h004, 0, 1, 16'h2001, 10'h002);
        v(0, 1, 0, 10'h000,  1, 10'h006, 0, 1, 16'h2002, 10'h004);
        v(0, 0, 0, 10'h000,  1, 10'h006, 0, 1, 16'h2002, 10'h004);
        v(0, 0, 0, 10'h000,  1, 10'h006, 0, 1, 16'h2002, 10'h004);
        v(0, 0, 0, 10'h000,  1, 10'h006, 0, 1, 16'h2002, 10'h004);
        v(0, 1, 0, 10'h000,  1, 10'h008, 0, 1, 16'h2003, 10'h006);
`ifdef IFETCH_JUMP_FOLD_EN
        v(0, 1, 0, 10'h000,  0, 10'd274, 0, 0, 16'h0000, 10'h000);
        v(0, 1, 0, 10'h000,  1, 10'd274, 0, 1, 16'h0000, 10'd274);
        v(0, 0, 1, 10'd10,   0, 10'd10,  0, 0, 16'h0000, 10'h000);
        v(0, 0, 0, 10'h000,  1, 10'd12,  0, 1, 16'h2005, 10'd10);
`else
        v(0, 1, 0, 10'h000,  1, 10'd10,  0, 1, 16'h1089, 10'd8);
        v(0, 1, 0, 10'h000,  1, 10'd12,  0, 1, 16'h2005, 10'd10);
        v(0, 0, 0, 10'h000,  1, 10'd12,  0, 1, 16'h2005, 10'd10);
`endif
        v(0, 0, 1, 10'h041,  0, 10'h040, 0, 0, 16'h0000, 10'h000);
        v(0, 0, 0, 10'h000,  1, 10'h042, 0, 1, 16'h2020, 10'h040);
        v(0, 1, 1, 10'h100,  0, 10'h100, 0, 0, 16'h0000, 10'h000);
        v(0, 1, 0, 10'h000,  1, 10'h102, 0, 1, 16'h2080, 10'h100);
        v(0, 1, 0, 10'h000,  1, 10'h104, 0, 1, 16'h2081, 10'h102);
        v(0, 1, 0, 10'h000,  1, 10'h104, 0, 1, 16'h0000, 10'h104);
        v(0, 0, 0, 10'h000,  1, 10'h104, 0, 1, 16'h0000, 10'h104);
        v(0, 0, 1, 10'h000,  0, 10'h000, 0, 0, 16'h0000, 10'h000);
        v(0, 1, 0, 10'h000,  1, 10'h002, 0, 1, 16'h2000, 10'h000);
        v(0, 1, 1, 10'h105,  0, 10'h104, 0, 0, 16'h0000, 10'h000);
        v(0, 0, 0, 10'h000,  1, 10'h104, 0, 1, 16'h0000, 10'h104);
        v(0, 1, 1, 10'h010,  0, 10'h104, 1, 0, 16'h0000, 10'h000);
        v(0, 1, 1, 10'h020,  0, 10'h104, 1, 0, 16'h0000, 10'h000);
        v(0, 0, 0, 10'h000,  0, 10'h104, 1, 0, 16'h0000, 10'h000);
        v(1, 1, 0, 10'h000,  0, 10'h000, 0, 1, 16'h0000, 10'h000);
        v(0, 1, 0, 10'h000,  1, 10'h002, 0, 1, 16'h2000, 10'h000);
        v(0, 1, 1, 10'h3FE,  0, 10'h3FE, 0, 0, 16'h0000, 10'h000);
        v(0, 1, 0, 10'h000,  1, 10'h000, 0, 1, 16'h21FF, 10'h3FE);
        v(0, 1, 0, 10'h000,  1, 10'h002, 0, 1, 16'h2000, 10'h000);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rst, vq[i].rdy, vq[i].redir, vq[i].rpc);
            cmp("valid",  i, 32'(instr_valid), 32'(vq[i].e_vld));
            cmp("addr",   i, 32'(imem_addr),   32'(vq[i].e_addr));
            cmp("halted", i, 32'(halted),      32'(vq[i].e_halt));
            if (vq[i].chk) begin
                cmp("instr",    i, 32'(instr),    32'(vq[i].e_instr));
                cmp("instr_pc", i, 32'(instr_pc), 32'(vq[i].e_pc));
            end
        end

        // Held reset keeps the slot empty; first word appears one cycle after release even with READY low.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 10'h000);
            cmp("rst_hold_valid", 100 + i, 32'(instr_valid), 32'd0);
            cmp("rst_hold_addr",  100 + i, 32'(imem_addr),   32'd0);
        end
        step(0, 0, 0, 10'h000);
        cmp("first_valid", 110, 32'(instr_valid), 32'd1);
        cmp("first_pc",    110, 32'(instr_pc),    32'd0);
        step(0, 0, 0, 10'h000);
        cmp("stall_pc",    111, 32'(instr_pc),    32'd0);
        cmp("stall_addr",  111, 32'(imem_addr),   32'd2);

`ifdef IFETCH_JUMP_FOLD_EN
        // A JUMP to itself spins silently until redirected away.
        mem[8] = 16'h1008;
        step(0, 1, 1, 10'd16);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 10'h000);
            cmp("loop_valid", 120 + i, 32'(instr_valid), 32'd0);
            cmp("loop_addr",  120 + i, 32'(imem_addr),   32'd16);
        end
        step(0, 1, 1, 10'd20);
        step(0, 1, 0, 10'h000);
        cmp("escape_valid", 130, 32'(instr_valid), 32'd1);
        cmp("escape_pc",    130, 32'(instr_pc),    32'd20);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
